// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle ripple adder that adds two WIDTH-bit operands
// CHUNK bits per clock, LSB chunk first, with the carry held in a flop between
// chunks. A full operation takes NCHUNK = WIDTH/CHUNK RUN cycles plus one DONE
// cycle.
//
// Handshake: start is sampled only when busy==0 (IDLE or DONE). The edge that
// samples start also latches a/b/ci. busy is high for exactly NCHUNK cycles,
// and then done pulses for one cycle with s/co/ovf valid. s/co/ovf are held
// until a later operation overwrites them.
//
// Optional feature macro: SEQ_ADDER_SUB_MODE_EN adds a `sub` input. When sub
// is 1 the block computes a - b: b is latched inverted and the carry is seeded
// with 1, so ci is ignored.
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef SEQ_ADDER_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK:0]   sum_c;

  // A request is taken whenever the block is not running.
  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == CW'(NCHUNK - 1));

  // The operand registers shift right every RUN cycle, so the live chunk is
  // always in their low bits.
  assign a_c   = a_q[CHUNK-1:0];
  assign b_c   = b_q[CHUNK-1:0];
  assign sum_c = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, carry};

`ifdef SEQ_ADDER_SUB_MODE_EN
  // Subtract is a + ~b + 1; ci plays no part in it.
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : ci;
`else
  assign b_load = b;
  assign c_load = ci;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last)   state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy      = (state == RUN);
    done      = (state == DONE);
    dbg_state = state;
  end

  // Datapath: latch operands on accept, then add one chunk per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      s     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b_load;
      carry <= c_load;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_q   <= a_q >> CHUNK;
      b_q   <= b_q >> CHUNK;
      carry <= sum_c[CHUNK];
      cnt   <= cnt + 1'b1;
      for (int k = 0; k < NCHUNK; k++) begin
        if (cnt == CW'(k)) s[k*CHUNK +: CHUNK] <= sum_c[CHUNK-1:0];
      end
      if (last) begin
        co  <= sum_c[CHUNK];
        // The carry into the MSB is recovered from the MSB sum bit.
        ovf <= sum_c[CHUNK] ^ (a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ sum_c[CHUNK-1]);
      end
    end
  end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Testbench for seq_chunk_adder (WIDTH=8, CHUNK=2). A reference model built
// from integer arithmetic predicts each result. Scenarios covered:
//   - reset
//   - directed corner cases
//   - start ignored during RUN
//   - back-to-back operations
//   - reset in the middle of an operation
//   - random operations
//   - subtract mode (only when SEQ_ADDER_SUB_MODE_EN is defined)
module tb_seq_chunk_adder;

  localparam int WIDTH  = 8;
  localparam int CHUNK  = 2;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int TMO    = 4 * NCHUNK + 20;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             ci    = 1'b0;
  logic             sub   = 1'b0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic [1:0]       dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH+1:0] exp_q[$];

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .ci        (ci),
`ifdef SEQ_ADDER_SUB_MODE_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .s         (s),
    .co        (co),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
    $fatal(1);
  end

  // Reference model: plain integer arithmetic, unsigned for s/co and signed
  // for ovf.
  function automatic void model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                input logic civ, input logic subv,
                                output logic [WIDTH-1:0] se, output logic coe,
                                output logic ovfe);
    longint half = longint'(1) << (WIDTH - 1);
    longint ua   = longint'(av);
    longint ub   = longint'(bv);
    longint full;
    longint sa;
    longint sb;
    longint res;
    if (subv) full = ua + ((2 * half - 1) - ub) + 1;
    else      full = ua + ub + longint'(civ);
    se  = full[WIDTH-1:0];
    coe = full[WIDTH];
    sa  = (ua >= half) ? ua - 2 * half : ua;
    sb  = (ub >= half) ? ub - 2 * half : ub;
    res = subv ? sa - sb : sa + sb + longint'(civ);
    ovfe = (res >= half) || (res < -half);
  endfunction

  // Driver: issue one operation, then watch it until done or timeout. When
  // poke is set, a new request with other operands is raised mid-RUN.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic civ, input logic subv, input bit poke,
                        output int bcnt, output bit got,
                        output logic [WIDTH-1:0] so, output logic coo,
                        output logic ovfo);
    @(posedge clk); #1;
    a = av; b = bv; ci = civ; sub = subv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom); sub = 1'($urandom);
    bcnt = 0; got = 0; so = '0; coo = 1'b0; ovfo = 1'b0;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1; so = s; coo = co; ovfo = ovf;
      end else begin
        if (busy) bcnt++;
        if (poke && bcnt == 2) begin
          start = 1'b1; a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
        end else begin
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, co, ovf} !== 4'b0000 || s !== '0 || dbg_state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_async: got busy=%b done=%b s=%0d co=%b ovf=%b st=%0d exp all 0",
               busy, done, s, co, ovf, dbg_state);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  // Run one operation and check latency, result, the single-cycle done and
  // that s is held afterwards.
  task automatic check_op(input string tag, input logic [WIDTH-1:0] av,
                          input logic [WIDTH-1:0] bv, input logic civ,
                          input logic subv, input bit poke);
    int               bcnt;
    bit               got;
    logic [WIDTH-1:0] so;
    logic [WIDTH-1:0] se;
    logic             coo;
    logic             ovfo;
    logic             coe;
    logic             ovfe;
    model(av, bv, civ, subv, se, coe, ovfe);
    run_op(av, bv, civ, subv, poke, bcnt, got, so, coo, ovfo);
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_done: got no done exp done within %0d cycles", tag, TMO);
    end
    n_cmp++;
    if (bcnt != NCHUNK) begin
      n_err++;
      $display("FAIL %s_busy: got %0d busy cycles exp %0d", tag, bcnt, NCHUNK);
    end
    n_cmp++;
    if (so !== se || coo !== coe || ovfo !== ovfe) begin
      n_err++;
      $display("FAIL %s_result: a=%0d b=%0d ci=%b sub=%b got s=%0d co=%b ovf=%b exp s=%0d co=%b ovf=%b",
               tag, av, bv, civ, subv, so, coo, ovfo, se, coe, ovfe);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || s !== se || co !== coe || ovf !== ovfe) begin
      n_err++;
      $display("FAIL %s_hold: got done=%b busy=%b s=%0d co=%b ovf=%b exp done=0 busy=0 s=%0d co=%b ovf=%b",
               tag, done, busy, s, co, ovf, se, coe, ovfe);
    end
  endtask

  task automatic test_directed();
    check_op("add_100_27", 8'd100, 8'd27, 1'b0, 1'b0, 1'b0);
    check_op("add_255_1", 8'd255, 8'd1, 1'b0, 1'b0, 1'b0);
    check_op("add_127_1", 8'd127, 8'd1, 1'b0, 1'b0, 1'b0);
    check_op("add_128_128_ci", 8'd128, 8'd128, 1'b1, 1'b0, 1'b0);
    check_op("add_255_255_ci", 8'd255, 8'd255, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_start_ignored();
    check_op("ignore_start", 8'd100, 8'd27, 1'b0, 1'b0, 1'b1);
    check_op("ignore_start2", 8'd200, 8'd99, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] se1;
    logic [WIDTH-1:0] se2;
    logic             coe1;
    logic             ovfe1;
    logic             coe2;
    logic             ovfe2;
    bit               got;
    int               bcnt;
    model(8'd127, 8'd1, 1'b0, 1'b0, se1, coe1, ovfe1);
    model(8'd60, 8'd70, 1'b1, 1'b0, se2, coe2, ovfe2);
    @(posedge clk); #1;
    a = 8'd127; b = 8'd1; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    got = 0;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    n_cmp++;
    if (!got || s !== se1 || co !== coe1 || ovf !== ovfe1) begin
      n_err++;
      $display("FAIL b2b_first: got done=%b s=%0d co=%b ovf=%b exp done=1 s=%0d co=%b ovf=%b",
               got, s, co, ovf, se1, coe1, ovfe1);
    end
    // Request is raised during the DONE cycle and must be taken directly.
    a = 8'd60; b = 8'd70; ci = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_nogap: got busy=%b done=%b exp busy=1 done=0", busy, done);
    end
    @(negedge clk);
    n_cmp++;
    if (co !== coe1 || ovf !== ovfe1) begin
      n_err++;
      $display("FAIL b2b_cohold: got co=%b ovf=%b exp co=%b ovf=%b", co, ovf, coe1, ovfe1);
    end
    got = 0; bcnt = 1;
    for (int i = 0; i < TMO && !got; i++) begin
      @(negedge clk);
      if (done) got = 1;
      else if (busy) bcnt++;
    end
    n_cmp++;
    if (!got || bcnt != NCHUNK || s !== se2 || co !== coe2 || ovf !== ovfe2) begin
      n_err++;
      $display("FAIL b2b_second: got done=%b busy=%0d s=%0d co=%b ovf=%b exp done=1 busy=%0d s=%0d co=%b ovf=%b",
               got, bcnt, s, co, ovf, NCHUNK, se2, coe2, ovfe2);
    end
  endtask

  task automatic test_reset_mid_run();
    int bcnt;
    bit saw_done;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00; ci = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    // Second RUN cycle: abort the operation.
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, co, ovf} !== 4'b0000 || s !== '0) begin
      n_err++;
      $display("FAIL midrun_reset: got busy=%b done=%b s=%0d co=%b ovf=%b exp all 0",
               busy, done, s, co, ovf);
    end
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < NCHUNK + 2; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL midrun_nodone: got activity after abort exp idle");
    end
    bcnt = 0;
    check_op("after_reset_3_4", 8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int               bcnt;
    bit               got;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] so;
    logic [WIDTH-1:0] se;
    logic             civ;
    logic             subv;
    logic             coo;
    logic             ovfo;
    logic             coe;
    logic             ovfe;
    logic [WIDTH+1:0] exp_v;
    for (int n = 0; n < 40; n++) begin
      av   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      bv   = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      civ  = 1'($urandom_range(0, 1));
`ifdef SEQ_ADDER_SUB_MODE_EN
      subv = 1'($urandom_range(0, 1));
`else
      subv = 1'b0;
`endif
      model(av, bv, civ, subv, se, coe, ovfe);
      exp_q.push_back({ovfe, coe, se});
      run_op(av, bv, civ, subv, 1'b0, bcnt, got, so, coo, ovfo);
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (!got || bcnt != NCHUNK || {ovfo, coo, so} !== exp_v) begin
        n_err++;
        $display("FAIL random_%0d: a=%0d b=%0d ci=%b sub=%b got done=%b busy=%0d {ovf,co,s}=%h exp done=1 busy=%0d %h",
                 n, av, bv, civ, subv, got, bcnt, {ovfo, coo, so}, NCHUNK, exp_v);
      end
    end
  endtask

`ifdef SEQ_ADDER_SUB_MODE_EN
  task automatic test_sub();
    check_op("sub_5_7", 8'd5, 8'd7, 1'b0, 1'b1, 1'b0);
    check_op("sub_128_1", 8'd128, 8'd1, 1'b1, 1'b1, 1'b0);
    check_op("sub_9_9", 8'd9, 8'd9, 1'b0, 1'b1, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
`ifdef SEQ_ADDER_SUB_MODE_EN
    test_sub();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
